axil_wr_decoder: RTL and testbench
==================================

// Module: axil_wr_decoder
// PURPOSE
//  Write-path address decoder and router for the AXI-Lite interconnect. Sits directly
//  downstream of the master arbiter: takes one granted master's AW/W/B channels,
//  decodes AWADDR against the slave address map and routes the transaction to one of
//  NUMBER_SLAVE slave ports. Unmapped addresses are absorbed locally with DECERR.
//  One outstanding write at a time; all slave-side and master-side outputs registered.
// PARAMETERS
//  NUMBER_SLAVE     16            number of slave ports
//  AXI_DATA_WIDTH   32            WDATA width; WSTRB is AXI_DATA_WIDTH/8
//  AXI_ADDR_WIDTH   32            AWADDR width
//  AXI_ADDR_OFFSET  i*32'h1000_0000  per-slave base address, array [NUMBER_SLAVE]
//  AXI_ADDR_RANGE   32'h0EFF_FFFF per-slave inclusive span, array [NUMBER_SLAVE]
// PORTS
//  aclk           in   1                      clock
//  areset         in   1                      synchronous reset, active-high
//  s_awaddr       in   AXI_ADDR_WIDTH         granted master write address
//  s_awvalid      in   1                      |  s_awready  out 1
//  s_wdata        in   AXI_DATA_WIDTH         write data
//  s_wstrb        in   AXI_DATA_WIDTH/8       write strobes
//  s_wvalid       in   1                      |  s_wready   out 1
//  s_bresp        out  2                      write response to master
//  s_bvalid       out  1                      |  s_bready   in  1
//  m_awaddr       out  AXI_ADDR_WIDTH         shared address to all slaves
//  m_awvalid      out  NUMBER_SLAVE           one-hot per-slave AW valid
//  m_awready      in   NUMBER_SLAVE           per-slave AW ready
//  m_wdata        out  AXI_DATA_WIDTH         shared write data
//  m_wstrb        out  AXI_DATA_WIDTH/8       shared write strobes
//  m_wvalid       out  NUMBER_SLAVE           one-hot per-slave W valid
//  m_wready       in   NUMBER_SLAVE           per-slave W ready
//  m_bresp        in   2*NUMBER_SLAVE         per-slave response, slave i at [2i+1:2i]
//  m_bvalid       in   NUMBER_SLAVE           per-slave B valid
//  m_bready       out  NUMBER_SLAVE           one-hot per-slave B ready
// BEHAVIOUR
//  Decode: slave i hits when OFFSET[i] <= addr <= OFFSET[i]+RANGE[i]; sum computed in
//   AXI_ADDR_WIDTH+1 bits (no wrap). Overlap -> lowest index wins. No hit -> miss.
//  FSM states: IDLE, WDATA, SLV_REQ, SLV_RESP, MST_RESP.
//  IDLE: s_awready=1. On s_awvalid: latch addr, sel index, hit flag -> WDATA.
//  WDATA: s_wready=1. On s_wvalid: latch wdata/wstrb; hit -> SLV_REQ;
//   miss -> MST_RESP with bresp=2'b11 (DECERR), no slave port touched.
//  SLV_REQ: m_awvalid[sel]=1 and m_wvalid[sel]=1 independently; each drops the cycle
//   after its own handshake (aw_done/w_done flags). Both done -> SLV_RESP.
//   m_awaddr/m_wdata/m_wstrb stable throughout.
//  SLV_RESP: m_bready[sel]=1; on m_bvalid[sel] latch m_bresp[sel] unchanged -> MST_RESP.
//  MST_RESP: s_bvalid=1, s_bresp stable until s_bready; then -> IDLE.
//  s_wready never asserted before AW accepted (AXI-legal); W early waits upstream.
//  Min latency (hit, zero-wait slave): AW accept c0, W c1, slave AW/W c2, B c3,
//   s_bvalid c4. Miss: s_bvalid c2.
//  m_* valid/ready vectors are one-hot or zero; never more than one bit set.
//  m_bvalid on non-selected slaves ignored (m_bready stays 0 there).
//  Reset: state=IDLE; all valid/ready outputs 0; s_bresp=2'b00; m_awaddr, m_wdata,
//   m_wstrb = 0. Reset mid-transaction abandons it immediately, no response issued.
// TESTING
//  Hit: AW 32'h3000_0010, W 32'hDEAD_BEEF/4'hF -> m_awvalid=16'h0008, m_awaddr
//   32'h3000_0010, m_wdata 32'hDEAD_BEEF; slave B OKAY -> s_bresp 2'b00 after handshake.
//  Miss: AW 32'h0F00_0000 -> no m_awvalid/m_wvalid bit ever set; s_bresp=2'b11.
//  Edges: AW 32'h3EFF_FFFF -> slave 3 hit; AW 32'h3F00_0000 -> DECERR;
//   AW 32'hFEFF_FFFF -> slave 15 hit (no wrap).
//  Skew: slave 7 m_awready 3 cycles after m_wready; SLVERR 2'b10 -> each valid drops
//   after its own handshake; s_bresp 2'b10 passed through.
//  Backpressure: s_bready low 10 cycles -> s_bvalid/s_bresp held stable; no new
//   s_awready until accepted.
//  Reset in SLV_REQ (slave 5) -> next cycle all valids 0, state IDLE; following
//   write to slave 2 completes normally with OKAY.

Source files
------------

// File: rtl/axil_wr_decoder_if.sv
// AXI-Lite write-path bundle between the granted master (s_*) and the slave fan-out (m_*).
// The decoder connects through the slave modport; the upstream/downstream model uses master.
interface axil_wr_decoder_if #(
  parameter int NUMBER_SLAVE   = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr;
  logic                        s_awvalid;
  logic                        s_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_wdata;
  logic [STRB_W-1:0]           s_wstrb;
  logic                        s_wvalid;
  logic                        s_wready;
  logic [1:0]                  s_bresp;
  logic                        s_bvalid;
  logic                        s_bready;

  logic [AXI_ADDR_WIDTH-1:0]   m_awaddr;
  logic [NUMBER_SLAVE-1:0]     m_awvalid;
  logic [NUMBER_SLAVE-1:0]     m_awready;
  logic [AXI_DATA_WIDTH-1:0]   m_wdata;
  logic [STRB_W-1:0]           m_wstrb;
  logic [NUMBER_SLAVE-1:0]     m_wvalid;
  logic [NUMBER_SLAVE-1:0]     m_wready;
  logic [2*NUMBER_SLAVE-1:0]   m_bresp;
  logic [NUMBER_SLAVE-1:0]     m_bvalid;
  logic [NUMBER_SLAVE-1:0]     m_bready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           m_awready, m_wready, m_bresp, m_bvalid,
    output s_awready, s_wready, s_bresp, s_bvalid,
           m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           m_awready, m_wready, m_bresp, m_bvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
  );
endinterface

// File: rtl/axil_wr_decoder.sv
// AXI-Lite write decoder: routes one write at a time from the granted master to the
// slave whose address window contains AWADDR; unmapped writes complete locally with DECERR.
module axil_wr_decoder #(
  parameter int NUMBER_SLAVE   = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = {
    32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000,
    32'hB000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000,
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
    {NUMBER_SLAVE{32'h0EFF_FFFF}}
) (
  input  logic             aclk,
  input  logic             areset,
  axil_wr_decoder_if.slave bus
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int SEL_W  = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;
  localparam logic [NUMBER_SLAVE-1:0] SEL_ONE = NUMBER_SLAVE'(1);

  typedef enum logic [2:0] {IDLE, WDATA, SLV_REQ, SLV_RESP, MST_RESP} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      hit_q, hit_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [NUMBER_SLAVE-1:0]   m_awvalid_q, m_awvalid_d;
  logic [NUMBER_SLAVE-1:0]   m_wvalid_q, m_wvalid_d;
  logic [NUMBER_SLAVE-1:0]   m_bready_q, m_bready_d;
  logic                      s_awready_q, s_awready_d;
  logic                      s_wready_q, s_wready_d;
  logic                      s_bvalid_q, s_bvalid_d;
  logic [1:0]                s_bresp_q, s_bresp_d;

  logic                      dec_hit;
  logic [SEL_W-1:0]          dec_sel;
  logic [NUMBER_SLAVE-1:0]   sel_oh;

  // Scan high-to-low so the lowest matching index wins on overlap; the upper bound is
  // formed one bit wider so a window touching the top of the address space cannot wrap.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUMBER_SLAVE - 1; i >= 0; i--) begin
      if (({1'b0, bus.s_awaddr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
          ({1'b0, bus.s_awaddr} <= ({1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]}))) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  assign sel_oh = SEL_ONE << sel_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    hit_d       = hit_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    s_awready_d = s_awready_q;
    s_wready_d  = s_wready_q;
    s_bvalid_d  = s_bvalid_q;
    s_bresp_d   = s_bresp_q;

    case (state_q)
      IDLE: begin
        s_awready_d = 1'b1;
        if (s_awready_q && bus.s_awvalid) begin
          addr_d      = bus.s_awaddr;
          sel_d       = dec_sel;
          hit_d       = dec_hit;
          s_awready_d = 1'b0;
          s_wready_d  = 1'b1;
          state_d     = WDATA;
        end
      end
      WDATA: begin
        if (s_wready_q && bus.s_wvalid) begin
          wdata_d    = bus.s_wdata;
          wstrb_d    = bus.s_wstrb;
          s_wready_d = 1'b0;
          if (hit_q) begin
            m_awvalid_d = sel_oh;
            m_wvalid_d  = sel_oh;
            state_d     = SLV_REQ;
          end else begin
            s_bvalid_d = 1'b1;
            s_bresp_d  = 2'b11;
            state_d    = MST_RESP;
          end
        end
      end
      SLV_REQ: begin
        // AW and W complete independently; the cleared valid bit doubles as the done flag.
        if (m_awvalid_q[sel_q] && bus.m_awready[sel_q]) m_awvalid_d = '0;
        if (m_wvalid_q[sel_q] && bus.m_wready[sel_q])   m_wvalid_d  = '0;
        if ((m_awvalid_d == '0) && (m_wvalid_d == '0)) begin
          m_bready_d = sel_oh;
          state_d    = SLV_RESP;
        end
      end
      SLV_RESP: begin
        if (m_bready_q[sel_q] && bus.m_bvalid[sel_q]) begin
          m_bready_d = '0;
          s_bresp_d  = bus.m_bresp[2*sel_q +: 2];
          s_bvalid_d = 1'b1;
          state_d    = MST_RESP;
        end
      end
      MST_RESP: begin
        if (bus.s_bready) begin
          s_bvalid_d  = 1'b0;
          s_awready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      hit_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      hit_q       <= hit_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      s_awready_q <= s_awready_d;
      s_wready_q  <= s_wready_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
    end
  end

  assign bus.s_awready = s_awready_q;
  assign bus.s_wready  = s_wready_q;
  assign bus.s_bvalid  = s_bvalid_q;
  assign bus.s_bresp   = s_bresp_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_awvalid = m_awvalid_q;
  assign bus.m_wvalid  = m_wvalid_q;
  assign bus.m_bready  = m_bready_q;
endmodule

// File: tb/tb_axil_wr_decoder.sv
// Directed bench for axil_wr_decoder: hit/miss routing, window edges, skewed slave
// handshakes, master backpressure and reset abandoning an in-flight write.
module tb_axil_wr_decoder;
  logic aclk = 1'b0;
  logic areset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 aclk = ~aclk;

  axil_wr_decoder_if #(.NUMBER_SLAVE(16), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus ();

  axil_wr_decoder dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // AW accepted on the first edge, W on the second; returns just after W acceptance.
  task automatic aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.s_awaddr  = a;
    bus.s_awvalid = 1'b1;
    step();
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = d;
    bus.s_wstrb   = s;
    bus.s_wvalid  = 1'b1;
    step();
    bus.s_wvalid  = 1'b0;
  endtask

  task automatic slv_b(input int s, input logic [1:0] r);
    bus.m_bresp[2*s +: 2] = r;
    bus.m_bvalid[s]       = 1'b1;
    step();
    bus.m_bvalid          = '0;
  endtask

  task automatic mst_b();
    bus.s_bready = 1'b1;
    step();
    bus.s_bready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b1;
    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.m_awready = '1;
    bus.m_wready  = '1;
    bus.m_bresp   = '1;
    bus.m_bvalid  = '0;
    step();
    step();
    chk("rst_awready", bus.s_awready, 0);
    chk("rst_wready",  bus.s_wready, 0);
    chk("rst_bvalid",  bus.s_bvalid, 0);
    chk("rst_bresp",   bus.s_bresp, 0);
    chk("rst_awvalid", bus.m_awvalid, 0);
    chk("rst_wvalid",  bus.m_wvalid, 0);
    chk("rst_bready",  bus.m_bready, 0);
    chk("rst_awaddr",  bus.m_awaddr, 0);
    chk("rst_wdata",   bus.m_wdata, 0);
    areset = 1'b0;
    step();
    chk("idle_awready", bus.s_awready, 1);

    // Hit slave 3, zero-wait slave, OKAY
    bus.s_awaddr  = 32'h3000_0010;
    bus.s_awvalid = 1'b1;
    step();
    bus.s_awvalid = 1'b0;
    chk("hit_awready_low", bus.s_awready, 0);
    chk("hit_wready",      bus.s_wready, 1);
    chk("hit_no_early_aw", bus.m_awvalid, 0);
    bus.s_wdata  = 32'hDEAD_BEEF;
    bus.s_wstrb  = 4'hF;
    bus.s_wvalid = 1'b1;
    step();
    bus.s_wvalid = 1'b0;
    chk("hit_awvalid", bus.m_awvalid, 16'h0008);
    chk("hit_wvalid",  bus.m_wvalid, 16'h0008);
    chk("hit_awaddr",  bus.m_awaddr, 32'h3000_0010);
    chk("hit_wdata",   bus.m_wdata, 32'hDEAD_BEEF);
    chk("hit_wstrb",   bus.m_wstrb, 4'hF);
    chk("hit_wready_low", bus.s_wready, 0);
    step();
    chk("hit_aw_drop", bus.m_awvalid, 0);
    chk("hit_w_drop",  bus.m_wvalid, 0);
    chk("hit_bready",  bus.m_bready, 16'h0008);
    chk("hit_no_bvalid_yet", bus.s_bvalid, 0);
    bus.m_bresp = '1;
    slv_b(3, 2'b00);
    chk("hit_bvalid", bus.s_bvalid, 1);
    chk("hit_bresp",  bus.s_bresp, 2'b00);
    chk("hit_bready_drop", bus.m_bready, 0);
    mst_b();
    chk("hit_done_bvalid", bus.s_bvalid, 0);
    chk("hit_done_awready", bus.s_awready, 1);

    // Miss below slave 0's window top boundary gap
    aw_w(32'h0F00_0000, 32'h1111_2222, 4'h1);
    chk("miss_awvalid", bus.m_awvalid, 0);
    chk("miss_wvalid",  bus.m_wvalid, 0);
    chk("miss_bvalid",  bus.s_bvalid, 1);
    chk("miss_bresp",   bus.s_bresp, 2'b11);
    step();
    chk("miss_hold_awvalid", bus.m_awvalid, 0);
    chk("miss_hold_bresp",   bus.s_bresp, 2'b11);
    mst_b();
    chk("miss_done_bvalid", bus.s_bvalid, 0);

    // Window edges
    aw_w(32'h3EFF_FFFF, 32'h0000_0001, 4'hF);
    chk("edge_top3_awvalid", bus.m_awvalid, 16'h0008);
    step();
    slv_b(3, 2'b00);
    mst_b();
    aw_w(32'h3F00_0000, 32'h0000_0002, 4'hF);
    chk("edge_gap_awvalid", bus.m_awvalid, 0);
    chk("edge_gap_bresp",   bus.s_bresp, 2'b11);
    mst_b();
    aw_w(32'hFEFF_FFFF, 32'h0000_0003, 4'hF);
    chk("edge_top15_awvalid", bus.m_awvalid, 16'h8000);
    step();
    chk("edge_top15_bready", bus.m_bready, 16'h8000);
    slv_b(15, 2'b01);
    chk("edge_top15_bresp", bus.s_bresp, 2'b01);
    mst_b();

    // Skew: slave 7 W accepted immediately, AW three cycles later; SLVERR
    bus.m_awready = '0;
    aw_w(32'h7000_0004, 32'h1234_5678, 4'h3);
    chk("skew_awvalid", bus.m_awvalid, 16'h0080);
    chk("skew_wvalid",  bus.m_wvalid, 16'h0080);
    step();
    chk("skew_w_drop",     bus.m_wvalid, 0);
    chk("skew_aw_hold1",   bus.m_awvalid, 16'h0080);
    step();
    step();
    chk("skew_aw_hold3",   bus.m_awvalid, 16'h0080);
    chk("skew_awaddr",     bus.m_awaddr, 32'h7000_0004);
    chk("skew_wdata",      bus.m_wdata, 32'h1234_5678);
    chk("skew_no_bready",  bus.m_bready, 0);
    bus.m_awready = '1;
    step();
    chk("skew_aw_drop", bus.m_awvalid, 0);
    chk("skew_bready",  bus.m_bready, 16'h0080);
    slv_b(7, 2'b10);
    chk("skew_bresp", bus.s_bresp, 2'b10);

    // Backpressure: master holds bready low with a new AW pending
    bus.s_awaddr  = 32'h2000_0000;
    bus.s_awvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_bvalid",  bus.s_bvalid, 1);
      chk("bp_bresp",   bus.s_bresp, 2'b10);
      chk("bp_awready", bus.s_awready, 0);
    end
    bus.s_awvalid = 1'b0;
    mst_b();
    chk("bp_done_bvalid",  bus.s_bvalid, 0);
    chk("bp_done_awready", bus.s_awready, 1);

    // Reset while slave 5 request is stalled
    bus.m_awready = '0;
    bus.m_wready  = '0;
    aw_w(32'h5000_0000, 32'hCAFE_F00D, 4'hF);
    chk("rst5_awvalid", bus.m_awvalid, 16'h0020);
    areset = 1'b1;
    step();
    chk("rst5_awvalid_clr", bus.m_awvalid, 0);
    chk("rst5_wvalid_clr",  bus.m_wvalid, 0);
    chk("rst5_bvalid",      bus.s_bvalid, 0);
    chk("rst5_awaddr",      bus.m_awaddr, 0);
    areset        = 1'b0;
    bus.m_awready = '1;
    bus.m_wready  = '1;
    step();
    chk("rst5_idle_awready", bus.s_awready, 1);

    // Normal write to slave 2 afterwards; a stray B from slave 5 must be ignored
    aw_w(32'h2000_0100, 32'hA5A5_5A5A, 4'hC);
    chk("s2_awvalid", bus.m_awvalid, 16'h0004);
    chk("s2_wstrb",   bus.m_wstrb, 4'hC);
    step();
    chk("s2_bready", bus.m_bready, 16'h0004);
    bus.m_bvalid = 16'h0020;
    bus.m_bresp  = '1;
    step();
    bus.m_bvalid = '0;
    chk("s2_stray_bvalid", bus.s_bvalid, 0);
    chk("s2_stray_bready", bus.m_bready, 16'h0004);
    slv_b(2, 2'b00);
    chk("s2_bvalid", bus.s_bvalid, 1);
    chk("s2_bresp",  bus.s_bresp, 2'b00);
    mst_b();
    chk("s2_done", bus.s_bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
